// File: rtl/serial_addsub_pkg.sv
// Shared state encoding and mode constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit.sv
// One-bit full adder / full subtractor cell. The sum/difference bit is the same
// XOR in both modes; only the carry/borrow equation depends on the mode.
module addsub_bit
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic mode,
  output logic r,
  output logic co
);

  assign r  = a ^ b ^ ci;
  assign co = (mode == MODE_ADD) ? ((a & b) | (ci & (a ^ b)))
                                 : ((~a & b) | (ci & ~(a ^ b)));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: operands captured on START, processed LSB first one
// bit per cycle, results published on entry to FIN and held until the next FIN.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             D,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] O1,
  output logic             O2,
  output logic             OVF
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Result bits shift in from the top; the final bit arrives combinationally,
  // so only WIDTH-1 bits need to be stored.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] res_nx;
  logic             mode, cy;
  logic             bit_r, bit_co;
  logic             last_bit;

  assign last_bit = (cnt == LAST);
  assign res_nx   = {bit_r, r_sh};

  addsub_bit u_bit (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .ci   (cy),
    .mode (mode),
    .r    (bit_r),
    .co   (bit_co)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: START only matters in IDLE; RUN ends after the last bit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (last_bit) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, publish on last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      mode <= MODE_ADD;
      cy   <= 1'b0;
      O1   <= '0;
      O2   <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_sh <= A;
            b_sh <= B;
            mode <= D;
            cy   <= C;
            cnt  <= '0;
            r_sh <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= res_nx[WIDTH-1:1];
          cy   <= bit_co;
          if (!last_bit) cnt <= cnt + CW'(1);
          if (last_bit) begin
            O1  <= res_nx;
            O2  <= bit_co;
            // cy is the carry/borrow into the MSB while the MSB is processed
            OVF <= cy ^ bit_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

endmodule
